// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : alternating I/D arbiter onto one shared memory port.
// Optional busy-state timeout when ARB_TIMEOUT_EN is defined.  Rev 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_request_i,
  input  logic [31:0] i_instAddr_i,
  input  logic        i_flush_i,
  output logic        i_dataOk_o,
  output logic [31:0] i_inst_o,
  input  logic        d_request_i,
  input  logic        d_write_i,
  input  logic [31:0] d_addr_i,
  input  logic [63:0] d_writeData_i,
  input  logic [7:0]  d_writeMask_i,
  output logic        d_dataOk_o,
  output logic [63:0] d_readData_o,
  output logic [2:0]  d_writeState_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wmask_o,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        d_error_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        flush_q, flush_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;
  logic        i_ok_q, i_ok_d;
  logic [31:0] i_inst_q, i_inst_d;
  logic        d_ok_q, d_ok_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic [2:0]  d_wstate_q, d_wstate_d;

  logic i_req_eff;
  logic grant_d;
  logic grant_i;
  logic i_flushed;

  assign i_req_eff = i_request_i && !i_flush_i;
  // Data wins a tie unless it won the previous grant.
  assign grant_d   = d_request_i && (!i_req_eff || !last_d_q);
  assign grant_i   = i_req_eff && (!d_request_i || last_d_q);
  assign i_flushed = flush_q || i_flush_i;

`ifdef ARB_TIMEOUT_EN
  localparam int         CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_err_q, d_err_d;
`else
  logic [31:0] unused_timeout_w;
  assign unused_timeout_w = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    flush_d     = flush_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    i_ok_d      = 1'b0;
    i_inst_d    = i_inst_q;
    d_ok_d      = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_wstate_d  = 3'b000;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_BUSY;
          last_d_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_write_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_writeData_i;
          mem_wmask_d = d_writeMask_i;
        end else if (grant_i) begin
          state_d     = I_BUSY;
          last_d_d    = 1'b0;
          flush_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_instAddr_i;
          mem_wdata_d = 64'd0;
          mem_wmask_d = 8'd0;
        end
      end
      I_BUSY: begin
        // A flush lets the bus cycle finish but swallows its result.
        flush_d = i_flushed;
        if (mem_ack_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (!i_flushed) begin
            i_ok_d   = 1'b1;
            i_inst_d = mem_addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
          end
        end
      end
      D_BUSY: begin
        if (mem_ack_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            d_wstate_d = 3'b111;
          end else begin
            d_ok_d    = 1'b1;
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef ARB_TIMEOUT_EN
    cnt_d   = '0;
    d_err_d = 1'b0;
    if ((state_q == I_BUSY || state_q == D_BUSY) && !mem_ack_i) begin
      if (cnt_q == CNT_LIMIT) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        d_err_d   = (state_q == D_BUSY);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      flush_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 64'd0;
      mem_wmask_q <= 8'd0;
      i_ok_q      <= 1'b0;
      i_inst_q    <= 32'd0;
      d_ok_q      <= 1'b0;
      d_rdata_q   <= 64'd0;
      d_wstate_q  <= 3'b000;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      d_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      flush_q     <= flush_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      i_ok_q      <= i_ok_d;
      i_inst_q    <= i_inst_d;
      d_ok_q      <= d_ok_d;
      d_rdata_q   <= d_rdata_d;
      d_wstate_q  <= d_wstate_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      d_err_q     <= d_err_d;
`endif
    end
  end

  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_wmask_o    = mem_wmask_q;
  assign i_dataOk_o     = i_ok_q;
  assign i_inst_o       = i_inst_q;
  assign d_dataOk_o     = d_ok_q;
  assign d_readData_o   = d_rdata_q;
  assign d_writeState_o = d_wstate_q;
`ifdef ARB_TIMEOUT_EN
  assign d_error_o      = d_err_q;
`else
  assign d_error_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : directed self-checking bench for mem_bus_arbiter.
// Rev 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_request_i;
  logic [31:0] i_instAddr_i;
  logic        i_flush_i;
  logic        i_dataOk_o;
  logic [31:0] i_inst_o;
  logic        d_request_i;
  logic        d_write_i;
  logic [31:0] d_addr_i;
  logic [63:0] d_writeData_i;
  logic [7:0]  d_writeMask_i;
  logic        d_dataOk_o;
  logic [63:0] d_readData_o;
  logic [2:0]  d_writeState_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic [63:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        d_error_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_request_i   (i_request_i),
    .i_instAddr_i  (i_instAddr_i),
    .i_flush_i     (i_flush_i),
    .i_dataOk_o    (i_dataOk_o),
    .i_inst_o      (i_inst_o),
    .d_request_i   (d_request_i),
    .d_write_i     (d_write_i),
    .d_addr_i      (d_addr_i),
    .d_writeData_i (d_writeData_i),
    .d_writeMask_i (d_writeMask_i),
    .d_dataOk_o    (d_dataOk_o),
    .d_readData_o  (d_readData_o),
    .d_writeState_o(d_writeState_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wmask_o   (mem_wmask_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_ack_i     (mem_ack_i),
    .d_error_o     (d_error_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve the current bus request: wait n cycles, then ack with rd.
  task automatic ack_after(input int n, input logic [63:0] rd, output int req_cycles);
    req_cycles = 0;
    for (int k = 0; k < n; k++) begin
      if (mem_req_o) req_cycles++;
      step();
    end
    if (mem_req_o) req_cycles++;
    mem_ack_i   = 1'b1;
    mem_rdata_i = rd;
    step();
    mem_ack_i   = 1'b0;
  endtask

  int rc;

  initial begin
    reset = 1'b1;  i_request_i = 1'b0; i_instAddr_i = 32'd0; i_flush_i = 1'b0;
    d_request_i = 1'b0; d_write_i = 1'b0; d_addr_i = 32'd0;
    d_writeData_i = 64'd0; d_writeMask_i = 8'd0;
    mem_rdata_i = 64'd0; mem_ack_i = 1'b0;
    step(); step();
    chk("rst_req",    {63'd0, mem_req_o}, 64'd0);
    chk("rst_addr",   {32'd0, mem_addr_o}, 64'd0);
    chk("rst_ok",     {62'd0, i_dataOk_o, d_dataOk_o}, 64'd0);
    chk("rst_wstate", {61'd0, d_writeState_o}, 64'd0);
    chk("rst_err",    {63'd0, d_error_o}, 64'd0);
    reset = 1'b0;
    step();

    // Single instruction fetch, upper word selected by addr bit 2
    i_request_i = 1'b1; i_instAddr_i = 32'h8000_0004;
    step();
    chk("i_grant_addr", {32'd0, mem_addr_o}, 64'h8000_0004);
    chk("i_grant_we",   {63'd0, mem_we_o}, 64'd0);
    ack_after(3, 64'h1234_5678_0000_0013, rc);
    chk("i_req_cycles", 64'(rc), 64'd4);
    chk("i_resp_ok",    {63'd0, i_dataOk_o}, 64'd1);
    chk("i_resp_inst",  {32'd0, i_inst_o}, 64'h1234_5678);
    chk("i_resp_req",   {63'd0, mem_req_o}, 64'd0);
    i_request_i = 1'b0;
    step();
    chk("i_ok_pulse",   {63'd0, i_dataOk_o}, 64'd0);

    // Alternation from reset with both requesters busy
    reset = 1'b1; step(); reset = 1'b0;
    i_request_i = 1'b1; i_instAddr_i = 32'h8000_0000;
    d_request_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h0000_0200;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("alt_grant", {32'd0, mem_addr_o}, (t % 2 == 0) ? 64'h200 : 64'h8000_0000);
      ack_after(0, 64'hCAFE_0000_1111_0000 + 64'(t), rc);
      chk("alt_ok", {62'd0, i_dataOk_o, d_dataOk_o}, (t % 2 == 0) ? 64'd1 : 64'd2);
      if (t % 2 == 0)
        chk("alt_rdata", d_readData_o, 64'hCAFE_0000_1111_0000 + 64'(t));
      else
        chk("alt_inst", {32'd0, i_inst_o}, 64'h1111_0000 + 64'(t));
      if (t == 3) begin
        i_request_i = 1'b0; d_request_i = 1'b0;
      end
      step();
    end

    // Data write, mask held until ack
    d_request_i = 1'b1; d_write_i = 1'b1; d_addr_i = 32'h100;
    d_writeData_i = 64'hDEAD_BEEF_CAFE_F00D; d_writeMask_i = 8'h0F;
    step();
    chk("w_we",    {63'd0, mem_we_o}, 64'd1);
    chk("w_mask",  {56'd0, mem_wmask_o}, 64'h0F);
    chk("w_data",  mem_wdata_o, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    chk("w_hold",  {55'd0, mem_req_o, mem_we_o, mem_wmask_o}, {55'd0, 1'b1, 1'b1, 8'h0F});
    ack_after(1, 64'd0, rc);
    chk("w_req_cycles", 64'(rc), 64'd2);
    chk("w_state", {61'd0, d_writeState_o}, 64'd7);
    chk("w_no_rdok", {63'd0, d_dataOk_o}, 64'd0);
    d_request_i = 1'b0; d_write_i = 1'b0;
    step();
    chk("w_state_pulse", {61'd0, d_writeState_o}, 64'd0);

    // Flush in IDLE blocks the grant that cycle
    i_request_i = 1'b1; i_instAddr_i = 32'h8000_0000; i_flush_i = 1'b1;
    step();
    chk("flush_idle_block", {63'd0, mem_req_o}, 64'd0);
    i_flush_i = 1'b0;
    step();
    chk("flush_idle_grant", {63'd0, mem_req_o}, 64'd1);
    // Flush while busy: memory cycle completes, result swallowed
    i_flush_i = 1'b1;
    step();
    i_flush_i = 1'b0;
    ack_after(1, 64'hAAAA_BBBB_CCCC_DDDD, rc);
    chk("flush_no_ok",  {63'd0, i_dataOk_o}, 64'd0);
    chk("flush_req_lo", {63'd0, mem_req_o}, 64'd0);
    i_request_i = 1'b0;
    step();
    chk("flush_idle", {63'd0, mem_req_o}, 64'd0);

    // Reset in D_BUSY, then a stray ack
    d_request_i = 1'b1; d_addr_i = 32'h300;
    step();
    chk("rd_busy_req", {63'd0, mem_req_o}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; d_request_i = 1'b0;
    chk("rb_req",   {63'd0, mem_req_o}, 64'd0);
    chk("rb_addr",  {32'd0, mem_addr_o}, 64'd0);
    chk("rb_rdata", d_readData_o, 64'd0);
    chk("rb_inst",  {32'd0, i_inst_o}, 64'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 64'h5555;
    step();
    mem_ack_i = 1'b0;
    chk("stray_ok", {59'd0, i_dataOk_o, d_dataOk_o, d_writeState_o}, 64'd0);
    step();
    chk("stray_ok2", {59'd0, i_dataOk_o, d_dataOk_o, d_writeState_o}, 64'd0);

`ifdef ARB_TIMEOUT_EN
    begin
      int req_n = 0;
      int err_n = 0;
      d_request_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h400;
      step();
      for (int k = 0; k < 20; k++) begin
        if (mem_req_o) req_n++;
        if (d_error_o) begin
          err_n++;
          d_request_i = 1'b0;
        end
        step();
      end
      d_request_i = 1'b0;
      chk("to_req_cycles", 64'(req_n), 64'd8);
      chk("to_err_pulses", 64'(err_n), 64'd1);
      chk("to_idle", {63'd0, mem_req_o}, 64'd0);
    end
`else
    d_request_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h400;
    step();
    for (int k = 0; k < 12; k++) step();
    chk("no_to_req_held", {63'd0, mem_req_o}, 64'd1);
    chk("no_to_err",      {63'd0, d_error_o}, 64'd0);
    d_request_i = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for mem_ack_i (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_request_i, input, 1, instruction read request, held until i_dataOk_o.
REQ-006 SHALL have port i_instAddr_i, input, 32, instruction address, stable while requesting.
REQ-007 SHALL have port i_flush_i, input, 1, jump flush; discards any pending or outstanding instruction response.
REQ-008 SHALL have port i_dataOk_o, output, 1, one-cycle instruction completion pulse.
REQ-009 SHALL have port i_inst_o, output, 32, fetched instruction, valid with i_dataOk_o.
REQ-010 SHALL have port d_request_i, input, 1, data request, held until d_dataOk_o or d_writeState_o == 3'b111.
REQ-011 SHALL have port d_write_i, input, 1, 1 = write, 0 = read.
REQ-012 SHALL have port d_addr_i, input, 32, data address.
REQ-013 SHALL have port d_writeData_i, input, 64, store data.
REQ-014 SHALL have port d_writeMask_i, input, 8, byte enables.
REQ-015 SHALL have port d_dataOk_o, output, 1, one-cycle read completion pulse.
REQ-016 SHALL have port d_readData_o, output, 64, load data, valid with d_dataOk_o.
REQ-017 SHALL have port d_writeState_o, output, 3, 3'b111 for one cycle on write completion, else 3'b000.
REQ-018 SHALL have port mem_req_o, mem_we_o, mem_addr_o[31:0], mem_wdata_o[63:0], mem_wmask_o[7:0], output, shared memory command, held until mem_ack_i.
REQ-019 SHALL have port mem_rdata_i[63:0], mem_ack_i, input, memory read data and one-cycle completion.
REQ-020 SHALL have port d_error_o, output, 1, timeout pulse for the data requester (ARB_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-021 SHALL implement a state machine with states IDLE, I_BUSY, D_BUSY and RESP.
REQ-022 In IDLE with only i_request_i (and no i_flush_i), SHALL go to I_BUSY and register the command (mem_we_o = 0, mem_addr_o = i_instAddr_i).
REQ-023 In IDLE with only d_request_i, SHALL go to D_BUSY and register d_* onto mem_*.
REQ-024 In IDLE with both requests, SHALL grant data unless the last grant was data, then grant instruction (alternating; no starvation).
REQ-025 mem_req_o SHALL rise the cycle after the grant decision and remain, with mem_* stable, until the cycle mem_ack_i is sampled high.
REQ-026 On mem_ack_i, SHALL deassert mem_req_o next cycle, enter RESP, and pulse the matching completion output for exactly that one RESP cycle.
REQ-027 The completion output is i_dataOk_o with i_inst_o = mem_rdata_i[31:0] (address bit 2 = 0) or mem_rdata_i[63:32] (bit 2 = 1); d_dataOk_o with d_readData_o = mem_rdata_i; or d_writeState_o = 3'b111.
REQ-028 RESP SHALL always return to IDLE; minimum back-to-back spacing is request, ack, RESP, IDLE, so a new grant occurs no earlier than the cycle after RESP.
REQ-029 i_flush_i in I_BUSY SHALL NOT abort the memory cycle; the I transaction completes and its i_dataOk_o is suppressed.
REQ-030 i_flush_i in IDLE SHALL block an instruction grant that cycle.
REQ-031 mem_ack_i in IDLE or RESP SHALL be ignored.
REQ-032 Completion outputs SHALL be mutually exclusive and never asserted outside RESP.

Reset
REQ-033 With reset high at a clock edge, state SHALL become IDLE, last-grant SHALL become instruction, and all outputs SHALL be 0 (mem_req_o, dataOk pulses, d_writeState_o = 3'b000, d_error_o, data and address buses).
REQ-034 Reset mid-transaction SHALL drop the outstanding response with no completion pulse; a later stray mem_ack_i SHALL be ignored per REQ-031.

Configuration
REQ-035 With macro ARB_TIMEOUT_EN defined, a counter SHALL run in I_BUSY/D_BUSY; after TIMEOUT_CYCLES cycles without mem_ack_i, SHALL drop mem_req_o, go to IDLE and pulse d_error_o once (D) or silently retry (I).
REQ-036 Without ARB_TIMEOUT_EN, there SHALL be no counter, busy states SHALL wait indefinitely, and d_error_o SHALL be tied 0.

Verification
REQ-037 Test: i_request_i = 1, i_instAddr_i = 0x80000004, ack after 3 cycles with rdata 0x12345678_0000_0013 -> mem_req_o for 4 cycles, i_dataOk_o for 1 cycle, i_inst_o = 0x12345678.
REQ-038 Test: both requests from reset -> D granted first; after D completion, I granted next; alternation continues over 4 transactions.
REQ-039 Test: D write, addr 0x100, data 0xDEADBEEF_CAFEF00D, mask 0x0F -> mem_we_o = 1 and mem_wmask_o = 0x0F held until ack; d_writeState_o = 3'b111 for exactly 1 cycle.
REQ-040 Test: i_flush_i pulsed during I_BUSY -> memory ack consumed, no i_dataOk_o, arbiter returns to IDLE.
REQ-041 Test: reset asserted while in D_BUSY -> all outputs 0 next cycle; an ack arriving afterwards produces no pulse.
REQ-042 Test (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): D read with no ack -> mem_req_o drops after 8 cycles, d_error_o pulses once, state returns to IDLE.
